// File: rtl/output_block_packer.sv
// Packs a stream of ELEM_WIDTH elements into OUTPUT0_SDIM-wide beats, with tlast
// marking the final beat of each OUTPUT0_BDIM-element block.

module obp_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module output_block_packer #(
  parameter int ELEM_WIDTH   = 8,
  parameter int OUTPUT0_SDIM = 4,
  parameter int OUTPUT0_BDIM = 16
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst_n,
  input  logic [ELEM_WIDTH-1:0]              s_axis_input0_tdata,
  input  logic                               s_axis_input0_tvalid,
  output logic                               s_axis_input0_tready,
  output logic [OUTPUT0_SDIM*ELEM_WIDTH-1:0] m_axis_output0_tdata,
  output logic                               m_axis_output0_tvalid,
  input  logic                               m_axis_output0_tready,
  output logic                               m_axis_output0_tlast
);
  localparam int SDIM  = (OUTPUT0_SDIM < 1) ? 1 : OUTPUT0_SDIM;
  localparam int BEATS = (OUTPUT0_BDIM / SDIM < 1) ? 1 : OUTPUT0_BDIM / SDIM;
  localparam int ECW   = (SDIM > 1) ? $clog2(SDIM) : 1;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ECW-1:0] ELEM_MAX = ECW'(SDIM - 1);
  localparam logic [BCW-1:0] BEAT_MAX = BCW'(BEATS - 1);

  generate
    if (OUTPUT0_SDIM < 1 || OUTPUT0_BDIM < OUTPUT0_SDIM ||
        (OUTPUT0_SDIM >= 1 && (OUTPUT0_BDIM % SDIM) != 0)) begin : g_bad_cfg
      $error("output_block_packer: OUTPUT0_BDIM must be a positive multiple of OUTPUT0_SDIM >= 1");
    end
  endgenerate

  typedef struct packed {
    logic                                 last;
    logic [SDIM-1:0][ELEM_WIDTH-1:0]      data;
  } beat_t;

  logic [ECW-1:0]                  elem_cnt;
  logic [BCW-1:0]                  beat_cnt;
  logic                            rst_done;
  logic [SDIM-1:0][ELEM_WIDTH-1:0] acc;
  logic [SDIM-1:0][ELEM_WIDTH-1:0] beat;
  beat_t                           out_q;
  logic                            out_valid;
  logic                            in_fire, out_fire, elem_last, beat_last, beat_done;

  assign elem_last = (elem_cnt == ELEM_MAX);
  assign beat_last = (beat_cnt == BEAT_MAX);

  // Stall input only when the completing element has nowhere to go; rst_done
  // keeps tready low through reset and until the first edge after release.
  assign s_axis_input0_tready = rst_done &
                                ~(elem_last & out_valid & ~m_axis_output0_tready);

  assign in_fire   = s_axis_input0_tvalid & s_axis_input0_tready;
  assign out_fire  = out_valid & m_axis_output0_tready;
  assign beat_done = in_fire & elem_last;

  genvar k;
  generate
    for (k = 0; k < SDIM; k++) begin : g_lane
      obp_lane #(.W(ELEM_WIDTH)) u_lane (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .we    (in_fire && (elem_cnt == ECW'(k))),
        .d     (s_axis_input0_tdata),
        .q     (acc[k])
      );
      // The lane being written this cycle bypasses its register into the beat.
      assign beat[k] = (elem_cnt == ECW'(k)) ? s_axis_input0_tdata : acc[k];
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      elem_cnt <= '0;
      beat_cnt <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (in_fire)   elem_cnt <= elem_last ? '0 : elem_cnt + 1'b1;
      if (beat_done) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (beat_done) begin
      out_q.data <= beat;
      out_q.last <= beat_last;
      out_valid  <= 1'b1;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

  assign m_axis_output0_tdata  = out_q.data;
  assign m_axis_output0_tlast  = out_q.last;
  assign m_axis_output0_tvalid = out_valid;
endmodule

// File: tb/tb_output_block_packer.sv
// Directed bench for output_block_packer (ELEM_WIDTH=8, SDIM=4, BDIM=16).

module tb_output_block_packer;
  logic        ap_clk, ap_rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;

  int checks = 0, failures = 0, stalls = 0, cyc = 0;
  logic [32:0] got_q[$];
  int          stamp_q[$];
  logic        rnd_done;

  output_block_packer #(.ELEM_WIDTH(8), .OUTPUT0_SDIM(4), .OUTPUT0_BDIM(16)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .s_axis_input0_tdata   (s_tdata),
    .s_axis_input0_tvalid  (s_tvalid),
    .s_axis_input0_tready  (s_tready),
    .m_axis_output0_tdata  (m_tdata),
    .m_axis_output0_tvalid (m_tvalid),
    .m_axis_output0_tready (m_tready),
    .m_axis_output0_tlast  (m_tlast)
  );

  initial begin
    ap_clk = 0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Inputs only change 1 time unit after posedge, so a handshake seen at
  // negedge is the one that completes at the next posedge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_tvalid && m_tready) begin
      got_q.push_back({m_tlast, m_tdata});
      stamp_q.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge ap_clk); #1; end
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    @(negedge ap_clk);
    while (!s_tready && n < 100) begin
      stalls++;
      n++;
      @(negedge ap_clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=stalled expected=accept data=%0h", d);
    end
    @(posedge ap_clk); #1;
    s_tvalid = 1'b0;
  endtask

  // Element j of a run is base+j; beat b packs elements 4b..4b+3, lane 0 first.
  task automatic check_beats(input string tag, input logic [7:0] base, input int n);
    logic [32:0] exp;
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int b = 0; b < n && b < got_q.size(); b++) begin
      for (int k = 0; k < 4; k++) exp[k*8 +: 8] = base + 8'(4*b + k);
      exp[32] = (b % 4 == 3);
      check(tag, 64'(got_q[b]), 64'(exp));
    end
  endtask

  initial begin
    int bad;
    ap_rst_n = 0; s_tvalid = 0; s_tdata = 0; m_tready = 0; rnd_done = 0;

    // Reset state
    #12;
    check("rst_tvalid", 64'(m_tvalid), 0);
    check("rst_tlast",  64'(m_tlast),  0);
    check("rst_tdata",  64'(m_tdata),  0);
    check("rst_tready", 64'(s_tready), 0);
    @(negedge ap_clk); #1;
    ap_rst_n = 1;
    #1 check("rel_tready_low", 64'(s_tready), 0);
    @(posedge ap_clk); #1;
    check("rel_tready_high", 64'(s_tready), 1);

    // 0x01..0x10 with downstream always ready
    m_tready = 1;
    got_q.delete();
    for (int i = 1; i <= 16; i++) begin
      send(8'(i));
      if (i == 3) check("r028_no_valid_yet", 64'(m_tvalid), 0);
      if (i == 4) begin
        check("r028_first_valid", 64'(m_tvalid), 1);
        check("r028_first_data",  64'(m_tdata), 64'h04030201);
      end
    end
    tick(2);
    check_beats("r028", 8'h01, 4);

    // 32 back-to-back elements: no input stalls, beats every 4 cycles
    got_q.delete(); stamp_q.delete(); stalls = 0;
    for (int i = 0; i < 32; i++) send(8'h20 + 8'(i));
    tick(2);
    check("r029_stalls", 64'(stalls), 0);
    check_beats("r029", 8'h20, 8);
    bad = 0;
    for (int b = 1; b < stamp_q.size(); b++) if (stamp_q[b] - stamp_q[b-1] != 4) bad++;
    check("r029_gaps", 64'(bad), 0);

    // Downstream stall with a completed beat pending
    got_q.delete();
    m_tready = 0;
    for (int i = 1; i <= 7; i++) send(8'(i));
    s_tvalid = 1; s_tdata = 8'h08;
    @(negedge ap_clk);
    check("r030_tready_low", 64'(s_tready), 0);
    check("r030_hold_valid", 64'(m_tvalid), 1);
    check("r030_hold_data",  64'(m_tdata), 64'h04030201);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("r030_still_data", 64'(m_tdata), 64'h04030201);
    check("r030_still_last", 64'(m_tlast), 0);
    @(posedge ap_clk); #1;
    m_tready = 1;
    @(negedge ap_clk);
    check("r030_tready_back", 64'(s_tready), 1);
    @(posedge ap_clk); #1;
    s_tvalid = 0;
    @(negedge ap_clk);
    check("r030_reload_valid", 64'(m_tvalid), 1);
    check("r030_reload_data",  64'(m_tdata), 64'h08070605);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check("r030_valid_falls", 64'(m_tvalid), 0);
    @(posedge ap_clk); #1;
    for (int i = 9; i <= 16; i++) send(8'(i));
    tick(2);
    check_beats("r030", 8'h01, 4);

    // Random bubbles and backpressure over 64 elements
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          if ($urandom_range(0, 2) == 0) tick(1);
          send(8'h40 + 8'(i));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge ap_clk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1;
    tick(4);
    check_beats("r031", 8'h40, 16);

    // Reset mid-block with a pending beat and partial accumulation
    got_q.delete();
    m_tready = 0;
    for (int i = 0; i < 6; i++) send(8'h51 + 8'(i));
    ap_rst_n = 0;
    #2;
    check("r032_rst_valid",  64'(m_tvalid), 0);
    check("r032_rst_last",   64'(m_tlast),  0);
    check("r032_rst_data",   64'(m_tdata),  0);
    check("r032_rst_tready", 64'(s_tready), 0);
    @(negedge ap_clk); #1;
    ap_rst_n = 1;
    @(posedge ap_clk); #1;
    check("r032_rel_tready", 64'(s_tready), 1);
    m_tready = 1;
    got_q.delete();
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i));
    tick(2);
    check_beats("r032", 8'hA0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/output_block_packer.md
OUTPUT_BLOCK_PACKER -- requirements
Module: output_block_packer

Interface
REQ-001 Parameter ELEM_WIDTH, default 8: bits per input element.
REQ-002 Parameter OUTPUT0_SDIM, default 4: elements per output beat (stream dimension).
REQ-003 Parameter OUTPUT0_BDIM, default 16: elements per block; tlast marks the final beat of each block.
REQ-004 Elaboration SHALL fail if OUTPUT0_BDIM is not a positive multiple of OUTPUT0_SDIM, or if OUTPUT0_SDIM < 1.
REQ-005 One clock; reset is asynchronous and active-low. The ports are ap_clk and ap_rst_n.
REQ-006 ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-007 ap_rst_n  input  1  asynchronous, active-low reset.
REQ-008 s_axis_input0_tdata  input  ELEM_WIDTH  one element per transfer.
REQ-009 s_axis_input0_tvalid  input  1  input element valid.
REQ-010 s_axis_input0_tready  output  1  block accepts the input element.
REQ-011 m_axis_output0_tdata  output  OUTPUT0_SDIM*ELEM_WIDTH  packed beat.
REQ-012 m_axis_output0_tvalid  output  1  output beat valid.
REQ-013 m_axis_output0_tready  input  1  downstream accepts the beat.
REQ-014 m_axis_output0_tlast  output  1  high on the last beat of each OUTPUT0_BDIM-element block.

Function
REQ-015 Input transfer occurs when s_tvalid and s_tready are both high at a rising edge; output transfer occurs when m_tvalid and m_tready are both high.
REQ-016 An element counter (0..OUTPUT0_SDIM-1) SHALL place each accepted element into an accumulation register lane equal to the counter value, then increment the counter, wrapping to 0 after OUTPUT0_SDIM-1.
REQ-017 Lane k occupies tdata bits [(k+1)*ELEM_WIDTH-1 : k*ELEM_WIDTH]; the first element of a beat is in lane 0.
REQ-018 On accepting the element at counter OUTPUT0_SDIM-1, the completed beat (accumulated lanes plus the current element) SHALL load the output register, and m_tvalid SHALL rise the next cycle (latency: 1 cycle after the last element of the beat).
REQ-019 A beat counter (0..OUTPUT0_BDIM/OUTPUT0_SDIM-1) SHALL advance on each completed beat and wrap after its maximum; m_tlast is registered with the beat and is high when the beat counter was at its maximum.
REQ-020 The output register holds tdata, tlast and tvalid stable until an output transfer; no field changes while m_tvalid is high and m_tready is low.
REQ-021 s_tready = NOT(element counter = OUTPUT0_SDIM-1 AND m_tvalid AND NOT m_tready); s_tready depends combinationally on m_tready only.
REQ-022 On a simultaneous output transfer and beat completion, the output register SHALL reload with the new beat and m_tvalid SHALL stay high (sustained rate: one element per cycle).
REQ-023 On an output transfer with no beat completing, m_tvalid SHALL fall the next cycle.
REQ-024 Partial beats are never emitted; lanes not yet written in the accumulation register are don't-care.

Reset
REQ-025 On ap_rst_n low, asynchronously: m_tvalid=0, m_tlast=0, m_tdata=0, both counters=0, accumulation register=0.
REQ-026 During reset s_tready SHALL be 0; it SHALL rise in the first cycle after ap_rst_n deasserts.
REQ-027 A reset mid-block discards all partially accumulated elements and any pending output beat; the next accepted element becomes lane 0 of beat 0 of a new block.

Verification (ELEM_WIDTH=8, OUTPUT0_SDIM=4, OUTPUT0_BDIM=16)
REQ-028 Stream 0x01..0x10 with m_tready=1 -> 4 beats 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; tlast only on the 4th; first m_tvalid 1 cycle after 0x04 is accepted.
REQ-029 Stream 32 elements continuously with m_tready=1 -> s_tready held high, 8 beats with no gaps, tlast on beats 4 and 8.
REQ-030 Hold m_tready=0 after the first beat completes -> s_tready falls when the element counter is 3, beat 0x04030201 held stable; raise m_tready -> beat transfers, the 8th element is accepted in the same cycle.
REQ-031 Insert random s_tvalid bubbles and m_tready stalls over 64 elements -> output matches the packed scoreboard, with tlast on every 4th beat.
REQ-032 Assert ap_rst_n low after 6 elements, then release and send 0xA0..0xAF -> first beat 0xA3A2A1A0, tlast on the 4th beat, and no remnant of the pre-reset data appears.
